instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle control sequencer for the 16-bit single-issue datapath. Fetches instructions from instruction memory over a req/ack handshake, holds each in an instruction register that drives the instruction decoder, and turns the decoder's raw LD/MW strobes into correctly timed register-file write and data-memory access enables. It owns the program counter and the run/halt state of the core.

## Interface
- PC_W, 8, program counter / instruction address width
- HALT_INST, 16'hFFFF, instruction encoding that stops the core
- CLK  in  1  system clock, all state updates on rising edge
- RST_N  in  1  asynchronous active-low reset
- RUN  in  1  level; 1 = execute instructions, 0 = stop at next instruction boundary
- IMEM_REQ  out  1  instruction fetch request
- IMEM_ADDR  out  PC_W  fetch address (equals PC)
- IMEM_ACK  in  1  fetch data valid this cycle
- IMEM_DATA  in  16  fetched instruction
- INST  out  16  instruction register, to decoder INST
- DEC_LD  in  1  decoder LD (raw register write request)
- DEC_MW  in  1  decoder MW (raw memory write request)
- DEC_MD  in  1  decoder MD (result from data memory)
- LD_EN  out  1  gated register-file write enable
- MW_EN  out  1  gated data-memory write enable
- DMEM_REQ  out  1  data-memory access request
- DMEM_ACK  in  1  data-memory access complete
- PC  out  PC_W  program counter
- HALTED  out  1  core has executed HALT_INST
- STATE  out  3  current FSM state encoding (debug)

## Operation
- Reset (RST_N=0, immediate): state IDLE, PC=0, INST=16'h0000; IMEM_REQ, DMEM_REQ, LD_EN, MW_EN, HALTED all 0. Reset asserted mid-instruction aborts it with no write enable issued after reset.
- States/encoding: IDLE=0, FETCH=1, DECODE=2, MEM=3, WB=4, HALT=5. Encodings 6,7 go to IDLE.
- IDLE: all strobes 0. RUN=1 -> FETCH.
- FETCH: IMEM_REQ=1, IMEM_ADDR=PC held stable. On IMEM_ACK=1: INST<=IMEM_DATA, -> DECODE. Otherwise stay; RUN is ignored while waiting.
- DECODE: INST stable, decoder outputs settle. INST==HALT_INST -> HALT (PC not incremented). Else DEC_MD=1 or DEC_MW=1 -> MEM. Else -> WB.
- MEM: DMEM_REQ=1; MW_EN=DEC_MW, held for every MEM cycle. On DMEM_ACK=1 -> WB.
- WB: LD_EN=DEC_LD for exactly this one cycle; PC<=PC+1 modulo 2^PC_W (wraps max->0). RUN=1 -> FETCH, RUN=0 -> IDLE.
- HALT: HALTED=1, all strobes 0, PC frozen; exits only via reset.
- LD_EN and MW_EN are never 1 outside WB and MEM respectively, regardless of decoder outputs.
- RUN dropping mid-instruction never cancels it; the instruction completes through WB.
- IMEM_ACK outside FETCH and DMEM_ACK outside MEM are ignored.

## Timing
- State, PC and INST are registers; all outputs are decoded from current state and INST (no path from IMEM_ACK/DMEM_ACK to any output).
- Zero-wait memories (ACK in first request cycle): ALU instruction 3 cycles (FETCH, DECODE, WB); memory instruction 4 cycles (FETCH, DECODE, MEM, WB).
- Each IMEM wait cycle adds one FETCH cycle; each DMEM wait cycle adds one MEM cycle.
- INST changes only on the clock edge leaving FETCH with ACK; constant from DECODE through WB.
- PC updates on the edge leaving WB; the following FETCH presents PC+1.
- From RUN rising in IDLE: IMEM_REQ asserts the next cycle.

## Test plan
- Reset: hold RST_N=0 then release with RUN=0 -> STATE=0, PC=0, INST=0, all strobes 0 indefinitely.
- ALU instruction, zero-wait: RUN=1, IMEM_DATA=16'h1234, DEC_LD=1, DEC_MD=DEC_MW=0 -> IMEM_REQ 1 cycle, LD_EN exactly 1 cycle in 3rd cycle, PC 0->1, next FETCH at address 1.
- Store with 2 DMEM wait cycles: DEC_MW=1, DEC_LD=0, DMEM_ACK on 3rd MEM cycle -> DMEM_REQ and MW_EN high 3 cycles, LD_EN never 1, total 6 cycles, PC increments once.
- Fetch stall and RUN drop: IMEM_ACK held 0 for 4 cycles with RUN dropped during stall -> IMEM_ADDR stable, instruction completes through WB, then IDLE with PC=1.
- Halt: IMEM_DATA=16'hFFFF at PC=5 -> HALT after DECODE, HALTED=1, PC stays 5, no further IMEM_REQ; RST_N pulse returns to IDLE with PC=0.
- Wrap and reset mid-op: PC_W=2, execute 4 ALU instructions -> PC sequence 1,2,3,0; assert RST_N=0 during MEM -> DMEM_REQ/MW_EN drop immediately.

Source files
------------

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: fetches over req/ack, holds the instruction register,
// owns PC and run/halt state, and gates raw decoder LD/MW into timed write enables.
module instr_sequencer #(
    parameter int          PC_W      = 8,
    parameter logic [15:0] HALT_INST = 16'hFFFF
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_run,
    output logic            o_imem_req,
    output logic [PC_W-1:0] o_imem_addr,
    input  logic            i_imem_ack,
    input  logic [15:0]     i_imem_data,
    output logic [15:0]     o_inst,
    input  logic            i_dec_ld,
    input  logic            i_dec_mw,
    input  logic            i_dec_md,
    output logic            o_ld_en,
    output logic            o_mw_en,
    output logic            o_dmem_req,
    input  logic            i_dmem_ack,
    output logic [PC_W-1:0] o_pc,
    output logic            o_halted,
    output logic [2:0]      o_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_inst;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_inst  <= 16'h0000;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && i_imem_ack)
                r_inst <= i_imem_data;
            // PC wraps naturally at 2^PC_W
            if (r_state == S_WB)
                r_pc <= r_pc + PC_W'(1);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_run) w_next = S_FETCH;
            S_FETCH:  if (i_imem_ack) w_next = S_DECODE;
            S_DECODE: begin
                if (r_inst == HALT_INST)
                    w_next = S_HALT;
                else if (i_dec_md || i_dec_mw)
                    w_next = S_MEM;
                else
                    w_next = S_WB;
            end
            S_MEM:    if (i_dmem_ack) w_next = S_WB;
            S_WB:     w_next = i_run ? S_FETCH : S_IDLE;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs depend only on registered state and INST, never on the acks.
    always_comb begin
        o_imem_req = 1'b0;
        o_dmem_req = 1'b0;
        o_ld_en    = 1'b0;
        o_mw_en    = 1'b0;
        o_halted   = 1'b0;
        case (r_state)
            S_FETCH: o_imem_req = 1'b1;
            S_MEM: begin
                o_dmem_req = 1'b1;
                o_mw_en    = i_dec_mw;
            end
            S_WB:    o_ld_en  = i_dec_ld;
            S_HALT:  o_halted = 1'b1;
            default: ;
        endcase
    end

    assign o_imem_addr = r_pc;
    assign o_pc        = r_pc;
    assign o_inst      = r_inst;
    assign o_state     = r_state;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench: each instruction is described by its parameters (waits, decoder bits,
// RUN at completion) and expanded into the expected cycle-by-cycle phase sequence.
module tb_instr_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_run;
    logic        o_imem_req;
    logic [7:0]  o_imem_addr;
    logic        i_imem_ack;
    logic [15:0] i_imem_data;
    logic [15:0] o_inst;
    logic        i_dec_ld, i_dec_mw, i_dec_md;
    logic        o_ld_en, o_mw_en, o_dmem_req;
    logic        i_dmem_ack;
    logic [7:0]  o_pc;
    logic        o_halted;
    logic [2:0]  o_state;

    int n_chk = 0;
    int n_err = 0;

    // reference model: architectural view only
    logic [7:0]  m_pc;
    logic [15:0] m_inst;
    logic        m_idle;

    instr_sequencer #(.PC_W(8), .HALT_INST(16'hFFFF)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_run(i_run),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data), .o_inst(o_inst),
        .i_dec_ld(i_dec_ld), .i_dec_mw(i_dec_mw), .i_dec_md(i_dec_md),
        .o_ld_en(o_ld_en), .o_mw_en(o_mw_en), .o_dmem_req(o_dmem_req),
        .i_dmem_ack(i_dmem_ack), .o_pc(o_pc), .o_halted(o_halted), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge with inputs already driven; checks at the
    // falling edge, returns just after the next rising edge.
    task automatic expect_cyc(input string tag, input logic [2:0] st, input logic ireq,
                              input logic dreq, input logic ld, input logic mw, input logic hlt);
        @(negedge i_clk);
        chk({tag, ".ctl"}, {26'd0, o_state, o_imem_req, o_dmem_req, o_ld_en, o_mw_en, o_halted},
            {26'd0, st, ireq, dreq, ld, mw, hlt});
        chk({tag, ".pc"}, {24'd0, o_pc}, {24'd0, m_pc});
        chk({tag, ".addr"}, {24'd0, o_imem_addr}, {24'd0, m_pc});
        chk({tag, ".inst"}, {16'd0, o_inst}, {16'd0, m_inst});
        @(posedge i_clk);
        #1;
    endtask

    task automatic noise_acks();
        i_imem_ack  = 1'($urandom);
        i_imem_data = 16'($urandom);
        i_dmem_ack  = 1'($urandom);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_run   = 1'b0;
        m_pc    = 8'd0;
        m_inst  = 16'h0000;
        m_idle  = 1'b1;
        #1;
        chk("rst.imm", {o_state, o_imem_req, o_dmem_req, o_ld_en, o_mw_en, o_halted, o_pc, o_inst},
            {3'd0, 5'd0, 8'd0, 16'h0000});
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            noise_acks();
            i_dec_ld = 1'b1; i_dec_mw = 1'b1; i_dec_md = 1'($urandom);
            expect_cyc("rst.idle", 3'd0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic run_instr(input logic [15:0] data, input int iw, input int dw,
                             input logic ld, input logic mw, input logic md, input logic run_end);
        i_dec_ld = ld; i_dec_mw = mw; i_dec_md = md;
        if (m_idle) begin
            noise_acks();
            i_run = 1'b1;
            expect_cyc("idle", 3'd0, 0, 0, 0, 0, 0);
        end
        for (int k = 0; k <= iw; k++) begin
            i_run       = (k == 0) ? 1'b1 : 1'($urandom);
            i_imem_ack  = (k == iw);
            i_imem_data = (k == iw) ? data : 16'($urandom);
            i_dmem_ack  = 1'($urandom);
            expect_cyc("fetch", 3'd1, 1, 0, 0, 0, 0);
        end
        m_inst = data;
        noise_acks();
        i_run = 1'($urandom);
        expect_cyc("decode", 3'd2, 0, 0, 0, 0, 0);
        if (data == 16'hFFFF) begin
            for (int k = 0; k < 5; k++) begin
                noise_acks();
                i_run = 1'($urandom);
                expect_cyc("halt", 3'd5, 0, 0, 0, 0, 1);
            end
            return;
        end
        if (mw || md) begin
            for (int k = 0; k <= dw; k++) begin
                i_imem_ack  = 1'($urandom);
                i_imem_data = 16'($urandom);
                i_dmem_ack  = (k == dw);
                i_run       = 1'($urandom);
                expect_cyc("mem", 3'd3, 0, 1, 0, mw, 0);
            end
        end
        noise_acks();
        i_run = run_end;
        expect_cyc("wb", 3'd4, 0, 0, ld, 0, 0);
        m_pc   = m_pc + 8'd1;
        m_idle = !run_end;
    endtask

    initial begin
        logic [15:0] d;
        i_rst_n = 1'b0; i_run = 1'b0;
        i_imem_ack = 1'b0; i_imem_data = 16'h0; i_dmem_ack = 1'b0;
        i_dec_ld = 1'b0; i_dec_mw = 1'b0; i_dec_md = 1'b0;
        @(posedge i_clk);
        #1;
        do_reset();

        // directed: ALU zero-wait, store with two DMEM waits, fetch stall with RUN drop
        run_instr(16'h1234, 0, 0, 1, 0, 0, 1);
        run_instr(16'h2345, 0, 2, 0, 1, 0, 1);
        run_instr(16'h3456, 4, 0, 1, 0, 0, 0);
        noise_acks();
        i_run = 1'b0;
        expect_cyc("stall.idle", 3'd0, 0, 0, 0, 0, 0);

        // random mix, long enough for PC to wrap past 255
        for (int n = 0; n < 300; n++) begin
            if (m_idle) begin
                for (int k = 0; k < int'($urandom_range(2)); k++) begin
                    noise_acks();
                    i_run = 1'b0;
                    expect_cyc("rnd.idle", 3'd0, 0, 0, 0, 0, 0);
                end
            end
            d = 16'($urandom);
            if (d == 16'hFFFF) d = 16'h0000;
            run_instr(d, int'($urandom_range(2)), int'($urandom_range(2)),
                      1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(3) != 0));
        end

        // halt at PC=5, then reset returns to IDLE with PC=0
        do_reset();
        for (int n = 0; n < 5; n++) run_instr(16'h0100 + 16'(n), 0, 0, 1, 0, 0, 1);
        run_instr(16'hFFFF, 1, 0, 1, 1, 1, 1);
        chk("halt.pc", {24'd0, o_pc}, 32'd5);
        do_reset();

        // reset during MEM drops DMEM_REQ/MW_EN immediately
        run_instr(16'h0001, 0, 0, 0, 0, 0, 0);
        i_dec_ld = 1'b1; i_dec_mw = 1'b1; i_dec_md = 1'b0;
        noise_acks(); i_run = 1'b1;
        expect_cyc("ab.idle", 3'd0, 0, 0, 0, 0, 0);
        i_imem_ack = 1'b1; i_imem_data = 16'h0BAD; i_dmem_ack = 1'b0;
        expect_cyc("ab.fetch", 3'd1, 1, 0, 0, 0, 0);
        m_inst = 16'h0BAD;
        i_imem_ack = 1'b0;
        expect_cyc("ab.decode", 3'd2, 0, 0, 0, 0, 0);
        expect_cyc("ab.mem", 3'd3, 0, 1, 0, 1, 0);
        #2;
        chk("ab.pre", {30'd0, o_dmem_req, o_mw_en}, 32'd3);
        do_reset();
        chk("ab.pc", {24'd0, o_pc}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
